// File: rtl/grid_renderer.sv
// Two-stage pixel colour generator for the game board: classifies each pixel as border, gap or cell,
// then colours it from a double-buffered board image with a blinking cursor highlight.
module grid_renderer #(
  parameter int          ROWS         = 4,
  parameter int          COLS         = 4,
  parameter int          CELL_W       = 100,
  parameter int          GAP_W        = 4,
  parameter int          ORIGIN_X     = 110,
  parameter int          ORIGIN_Y     = 30,
  parameter int          V_ACTIVE     = 480,
  parameter logic [11:0] BORDER_COLOR = 12'h94F,
  parameter logic [11:0] GAP_COLOR    = 12'hFA0,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [9:0]                x,
  input  logic [9:0]                y,
  input  logic                      videoOn,
  input  logic [ROWS*COLS*12-1:0]   board,
  input  logic                      boardValid,
  input  logic                      cursorEn,
  input  logic [2:0]                cursorRow,
  input  logic [2:0]                cursorCol,
  input  logic                      blinkEn,
  output logic [11:0]               rgb,
  output logic                      boardLoaded
);

  localparam int PITCH  = CELL_W + GAP_W;
  localparam int GRID_W = COLS * CELL_W + (COLS + 1) * GAP_W;
  localparam int GRID_H = ROWS * CELL_W + (ROWS + 1) * GAP_W;
  localparam int NCELL  = ROWS * COLS;
  localparam int IDX_W  = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int FC_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [10:0] X_LO = 11'(ORIGIN_X);
  localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);

  typedef enum logic [1:0] {
    REG_BORDER,
    REG_GAP,
    REG_CELL
  } region_t;

  // Offsets wrap to large values left of / above the origin, so one
  // unsigned compare against the grid size covers both edges.
  logic [10:0] ox;
  logic [10:0] oy;
  logic        in_x;
  logic        in_y;
  assign ox   = {1'b0, x} - X_LO;
  assign oy   = {1'b0, y} - Y_LO;
  assign in_x = ox < 11'(GRID_W);
  assign in_y = oy < 11'(GRID_H);

  logic [COLS:0]   gap_col;
  logic [ROWS:0]   gap_row;
  logic [COLS-1:0] in_col;
  logic [ROWS-1:0] in_row;

  generate
    for (genvar gi = 0; gi <= COLS; gi++) begin : g_gap_col
      assign gap_col[gi] = (ox - 11'(gi * PITCH)) < 11'(GAP_W);
    end
    for (genvar gi = 0; gi <= ROWS; gi++) begin : g_gap_row
      assign gap_row[gi] = (oy - 11'(gi * PITCH)) < 11'(GAP_W);
    end
    for (genvar gi = 0; gi < COLS; gi++) begin : g_in_col
      assign in_col[gi] = (ox - 11'(gi * PITCH)) < 11'(PITCH);
    end
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_in_row
      assign in_row[gi] = (oy - 11'(gi * PITCH)) < 11'(PITCH);
    end
  endgenerate

  logic [2:0]       col_idx;
  logic [2:0]       row_idx;
  logic             blink_on;
  region_t          region_next;
  logic [IDX_W-1:0] cell_next;
  logic             hl_next;

  always_comb begin
    col_idx     = '0;
    row_idx     = '0;
    region_next = REG_BORDER;
    for (int i = 0; i < COLS; i++) begin
      if (in_col[i]) col_idx = 3'(i);
    end
    for (int i = 0; i < ROWS; i++) begin
      if (in_row[i]) row_idx = 3'(i);
    end
    if (in_x && in_y) begin
      region_next = ((|gap_col) || (|gap_row)) ? REG_GAP : REG_CELL;
    end
  end

  logic phase_reg;
  assign blink_on  = blinkEn ? phase_reg : 1'b1;
  // Out-of-range cursor indices never equal a real row/column index.
  assign hl_next   = cursorEn && (cursorRow == row_idx) && (cursorCol == col_idx) && blink_on;
  assign cell_next = IDX_W'({3'b000, row_idx} * 6'(COLS) + {3'b000, col_idx});

  logic             vid_reg;
  region_t          region_reg;
  logic [IDX_W-1:0] cell_reg;
  logic             hl_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      vid_reg    <= 1'b0;
      region_reg <= REG_BORDER;
      cell_reg   <= '0;
      hl_reg     <= 1'b0;
    end else begin
      vid_reg    <= videoOn;
      region_reg <= region_next;
      cell_reg   <= cell_next;
      hl_reg     <= hl_next;
    end
  end

  logic [NCELL*12-1:0] active_reg;
  logic [NCELL*12-1:0] pending_reg;
  logic                pend_valid_reg;
  logic [FC_W-1:0]     frame_cnt_reg;
  logic [11:0]         cell_color [NCELL];

  generate
    for (genvar gi = 0; gi < NCELL; gi++) begin : g_cell_color
      assign cell_color[gi] = active_reg[gi*12 +: 12];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb <= 12'h000;
    end else if (!vid_reg) begin
      rgb <= 12'h000;
    end else begin
      case (region_reg)
        REG_GAP:  rgb <= GAP_COLOR;
        REG_CELL: rgb <= cell_color[cell_reg] ^ {12{hl_reg}};
        default:  rgb <= BORDER_COLOR;
      endcase
    end
  end

  // Swapping buffers only on the first blanked line keeps a frame from tearing.
  logic commit;
  assign commit = (x == 10'd0) && (y == 10'(V_ACTIVE));

  always_ff @(posedge clk) begin
    if (reset) begin
      active_reg     <= '0;
      pending_reg    <= '0;
      pend_valid_reg <= 1'b0;
      frame_cnt_reg  <= '0;
      phase_reg      <= 1'b0;
      boardLoaded    <= 1'b0;
    end else begin
      boardLoaded <= commit && pend_valid_reg;
      if (commit && pend_valid_reg) begin
        active_reg <= pending_reg;
      end
      if (boardValid) begin
        pending_reg    <= board;
        pend_valid_reg <= 1'b1;
      end else if (commit) begin
        pend_valid_reg <= 1'b0;
      end
      if (commit) begin
        if (frame_cnt_reg == FC_W'(BLINK_FRAMES - 1)) begin
          frame_cnt_reg <= '0;
          phase_reg     <= ~phase_reg;
        end else begin
          frame_cnt_reg <= frame_cnt_reg + FC_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_grid_renderer.sv
// Randomized scoreboard bench for grid_renderer: a frame-level reference model predicts every
// pixel colour and boardLoaded value; a monitor pops and compares them as the DUT produces them.
module tb_grid_renderer;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int NC   = ROWS * COLS;

  logic            clk = 1'b0;
  logic            reset;
  logic [9:0]      x;
  logic [9:0]      y;
  logic            videoOn;
  logic [NC*12-1:0] board;
  logic            boardValid;
  logic            cursorEn;
  logic [2:0]      cursorRow;
  logic [2:0]      cursorCol;
  logic            blinkEn;
  logic [11:0]     rgb;
  logic            boardLoaded;

  always #5 clk = ~clk;

  grid_renderer dut (
    .clk        (clk),
    .reset      (reset),
    .x          (x),
    .y          (y),
    .videoOn    (videoOn),
    .board      (board),
    .boardValid (boardValid),
    .cursorEn   (cursorEn),
    .cursorRow  (cursorRow),
    .cursorCol  (cursorCol),
    .blinkEn    (blinkEn),
    .rgb        (rgb),
    .boardLoaded(boardLoaded)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int          q_rgb_due[$];
  logic [11:0] q_rgb_val[$];
  string       q_rgb_tag[$];
  int          q_ld_due[$];
  logic        q_ld_val[$];

  // Reference model state: whole-board images and a frame counter.
  logic [11:0] m_active[NC];
  logic [11:0] m_pending[NC];
  bit          m_pv;
  int          m_frames;
  bit          m_phase;

  function automatic logic [11:0] model_pixel(int px, int py, bit pv);
    int ox, oy, r, c;
    logic [11:0] col;
    if (!pv) return 12'h000;
    ox = px - 110;
    oy = py - 30;
    if (ox < 0 || ox >= 420 || oy < 0 || oy >= 420) return 12'h94F;
    if ((ox % 104) < 4 || (oy % 104) < 4) return 12'hFA0;
    c = ox / 104;
    r = oy / 104;
    col = m_active[r*COLS + c];
    if (cursorEn && int'(cursorRow) == r && int'(cursorCol) == c && (blinkEn ? m_phase : 1'b1))
      col = col ^ 12'hFFF;
    return col;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_active[i]  = 12'h000;
      m_pending[i] = 12'h000;
    end
    m_pv     = 0;
    m_frames = 0;
    m_phase  = 0;
  endtask

  // Apply one pixel's inputs, predict its outputs, advance one clock.
  task automatic step(input int px, input int py, input bit pv, input bit bv, input bit rs,
                      input int want, input string tag);
    logic [11:0] e;
    bit commit;
    x = 10'(px);
    y = 10'(py);
    videoOn = pv;
    boardValid = bv;
    reset = rs;
    if (rs) begin
      foreach (q_rgb_val[i]) if (q_rgb_due[i] > cyc) q_rgb_val[i] = 12'h000;
      q_rgb_due.push_back(cyc + 2); q_rgb_val.push_back(12'h000); q_rgb_tag.push_back(tag);
      q_ld_due.push_back(cyc + 1);  q_ld_val.push_back(1'b0);
      model_reset();
    end else begin
      e = (want >= 0) ? 12'(want) : model_pixel(px, py, pv);
      q_rgb_due.push_back(cyc + 2); q_rgb_val.push_back(e); q_rgb_tag.push_back(tag);
      commit = (px == 0) && (py == 480);
      q_ld_due.push_back(cyc + 1); q_ld_val.push_back(commit && m_pv);
      if (commit && m_pv) m_active = m_pending;
      if (commit) begin
        if (m_frames == 29) begin
          m_frames = 0;
          m_phase  = ~m_phase;
        end else begin
          m_frames++;
        end
      end
      if (bv) begin
        for (int i = 0; i < NC; i++) m_pending[i] = board[i*12 +: 12];
        m_pv = 1;
      end else if (commit) begin
        m_pv = 0;
      end
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    while (q_rgb_due.size() > 0 && q_rgb_due[0] <= cyc) begin
      logic [11:0] ev;
      string tg;
      ev = q_rgb_val.pop_front();
      tg = q_rgb_tag.pop_front();
      void'(q_rgb_due.pop_front());
      checks++;
      if (rgb !== ev) begin
        errors++;
        $display("FAIL rgb %s @%0d: got %h expected %h", tg, cyc, rgb, ev);
      end else if (tg != "rand") begin
        $display("rgb %s @%0d: got %h expected %h ok", tg, cyc, rgb, ev);
      end
    end
    while (q_ld_due.size() > 0 && q_ld_due[0] <= cyc) begin
      logic lv;
      lv = q_ld_val.pop_front();
      void'(q_ld_due.pop_front());
      checks++;
      if (boardLoaded !== lv) begin
        errors++;
        $display("FAIL boardLoaded @%0d: got %b expected %b", cyc, boardLoaded, lv);
      end else if (lv) begin
        $display("boardLoaded pulse @%0d ok", cyc);
      end
    end
  end

  task automatic rand_board();
    for (int i = 0; i < NC; i++) board[i*12 +: 12] = 12'($urandom);
  endtask

  initial begin
    reset = 1'b1; x = '0; y = '0; videoOn = 1'b0; board = '0; boardValid = 1'b0;
    cursorEn = 1'b0; cursorRow = '0; cursorCol = '0; blinkEn = 1'b0;
    model_reset();
    @(negedge clk);
    repeat (3) step(0, 0, 0, 0, 1, -1, "reset");
    step(114, 34, 1, 0, 0, 12'h000, "first_frame_cell");
    step(200, 40, 1, 0, 0, 12'h000, "first_frame_cell2");

    // Load a board with known cells and commit it.
    rand_board();
    board[0*12 +: 12]  = 12'h123;
    board[15*12 +: 12] = 12'hABC;
    board[6*12 +: 12]  = 12'h0F0;
    step(300, 200, 1, 1, 0, -1, "load_strobe");
    step(0, 480, 1, 0, 0, -1, "commit");
    step(114, 34, 1, 0, 0, 12'h123, "cell00");
    step(113, 34, 1, 0, 0, 12'hFA0, "gap_left");
    step(109, 34, 1, 0, 0, 12'h94F, "border_left");
    step(529, 34, 1, 0, 0, 12'hFA0, "gap_right");
    step(530, 34, 1, 0, 0, 12'h94F, "border_right");
    step(114, 34, 0, 0, 0, 12'h000, "video_off");
    step(426, 346, 1, 0, 0, 12'hABC, "cell33_tl");
    step(525, 346, 1, 0, 0, 12'hABC, "cell33_tr");
    step(426, 445, 1, 0, 0, 12'hABC, "cell33_bl");
    step(525, 445, 1, 0, 0, 12'hABC, "cell33_br");
    step(525, 446, 1, 0, 0, 12'hFA0, "gap_bottom");
    step(700, 34, 1, 0, 0, 12'h94F, "beyond_640");

    // Mid-frame board update: old colours persist until the commit point.
    rand_board();
    step(300, 200, 1, 1, 0, -1, "midframe_strobe");
    step(114, 34, 1, 0, 0, 12'h123, "old_colour");
    for (int i = 0; i < 40; i++)
      step($urandom_range(100, 540), $urandom_range(20, 479), 1, 0, 0, -1, "rand");
    step(0, 480, 1, 0, 0, -1, "commit_new");
    step(114, 34, 1, 0, 0, -1, "new_colour");
    step(0, 480, 1, 0, 0, -1, "commit_empty");

    // Cursor highlight, steady then blinking.
    board[6*12 +: 12] = 12'h0F0;
    step(300, 200, 1, 1, 0, -1, "cursor_board");
    step(0, 480, 1, 0, 0, -1, "commit_cursor");
    cursorEn = 1'b1; cursorRow = 3'd1; cursorCol = 3'd2; blinkEn = 1'b0;
    step(330, 150, 1, 0, 0, 12'hF0F, "cursor_steady");
    cursorRow = 3'd5;
    step(330, 150, 1, 0, 0, 12'h0F0, "cursor_row_oob");
    cursorRow = 3'd1;
    blinkEn = 1'b1;
    for (int f = 0; f < 65; f++) begin
      step(0, 480, 1, 0, 0, -1, "rand");
      step(330, 150, 1, 0, 0, -1, "blink");
    end
    cursorEn = 1'b0; blinkEn = 1'b0;

    // Strobe on the commit cycle: commit takes old pending, new board stays pending.
    rand_board();
    step(300, 200, 1, 1, 0, -1, "pend_a");
    rand_board();
    step(0, 480, 1, 1, 0, -1, "commit_with_strobe");
    step(430, 250, 1, 0, 0, -1, "after_commit_a");
    step(0, 480, 1, 0, 0, -1, "commit_b");
    step(430, 250, 1, 0, 0, -1, "after_commit_b");

    // Reset mid-frame.
    step(200, 100, 1, 0, 0, -1, "pre_reset");
    step(200, 100, 1, 0, 1, -1, "mid_reset");
    step(114, 34, 1, 0, 0, 12'h000, "post_reset_cell");
    step(530, 34, 1, 0, 0, 12'h94F, "post_reset_border");
    step(0, 480, 1, 0, 0, -1, "commit_after_reset");
    step(430, 250, 1, 0, 0, 12'h000, "post_reset_cell2");

    // Fully randomized traffic.
    for (int i = 0; i < 500; i++) begin
      int px, py;
      bit bv, rs;
      cursorEn  = 1'($urandom_range(0, 1));
      cursorRow = 3'($urandom);
      cursorCol = 3'($urandom);
      blinkEn   = 1'($urandom_range(0, 1));
      bv = ($urandom_range(0, 15) == 0);
      if (bv) rand_board();
      rs = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 9) == 0) begin
        px = 0; py = 480;
      end else if ($urandom_range(0, 1) == 0) begin
        px = $urandom_range(100, 540); py = $urandom_range(20, 460);
      end else begin
        px = $urandom_range(0, 1023); py = $urandom_range(0, 1023);
      end
      step(px, py, $urandom_range(0, 7) != 0, bv, rs, -1, "rand");
    end

    repeat (2) step(1, 1, 0, 0, 0, -1, "idle");
    for (int i = 0; i < 10 && (q_rgb_due.size() > 0 || q_ld_due.size() > 0); i++) @(negedge clk);
    if (q_rgb_due.size() > 0 || q_ld_due.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d outstanding expectations, required 0",
               q_rgb_due.size() + q_ld_due.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
